// File: rtl/control_sequencer.sv
// control_sequencer: decodes instructions into a 13-bit control word, EXEC then WB (nWE low, done pulse).
// Latency: handshake edge -> EXEC -> WB, one instruction per 2 cycles. Optional 2-entry input FIFO: CU_IBUF_EN.
// Backpressure: instr_ready only in IDLE/WB, or !full when CU_IBUF_EN is defined; low until reset release settles.

`ifdef CU_IBUF_EN
module cs_fifo #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_vld,
   output logic         push_rdy,
   input  logic [W-1:0] push_dat,
   output logic         pop_vld,
   input  logic         pop_rdy,
   output logic [W-1:0] pop_dat
);
   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt;
   logic         do_push;
   logic         do_pop;

   assign push_rdy = (cnt != 2'd2);
   assign pop_vld  = (cnt != 2'd0);
   assign pop_dat  = mem[rd_ptr];
   assign do_push  = push_vld && push_rdy;
   assign do_pop   = pop_vld && pop_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule
`endif

module control_sequencer (
   input  logic        clk,
   input  logic        nRST,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [12:0] ControlWord,
   output logic [3:0]  ConstantIn,
   output logic        busy,
   output logic        done,
   output logic [7:0]  instr_count
);
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t      state;
   logic [1:0]  rst_sync;
   logic        rst_n;
   logic        can_take;
   logic        take_vld;
   logic [15:0] take_dat;

   function automatic logic [12:0] decode(input logic [15:0] i);
      return {i[11:10], i[9:8], i[7:6], i[5], i[15:12], i[4], 1'b1};
   endfunction

   // Assert asynchronously, release two edges after nRST rises.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST)
         rst_sync <= 2'b00;
      else
         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign can_take = (state == IDLE) || (state == WB);

`ifdef CU_IBUF_EN
   logic        fifo_push_rdy;
   logic        fifo_vld;
   logic        fifo_push;
   logic [15:0] fifo_dat;

   // An empty FIFO is bypassed so an idle sequencer still starts EXEC on the handshake edge.
   assign instr_ready = rst_n && fifo_push_rdy;
   assign fifo_push   = instr_valid && instr_ready && !(can_take && !fifo_vld);
   assign take_vld    = fifo_vld || (instr_valid && instr_ready);
   assign take_dat    = fifo_vld ? fifo_dat : instr;

   cs_fifo #(.W(16)) u_ibuf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (fifo_push),
      .push_rdy (fifo_push_rdy),
      .push_dat (instr),
      .pop_vld  (fifo_vld),
      .pop_rdy  (can_take),
      .pop_dat  (fifo_dat)
   );
`else
   // The output registers hold the in-flight instruction; they free up on the WB edge.
   assign instr_ready = rst_n && can_take;
   assign take_vld    = instr_valid && instr_ready;
   assign take_dat    = instr;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ControlWord <= 13'h0001;
         ConstantIn  <= 4'h0;
         busy        <= 1'b0;
         done        <= 1'b0;
         instr_count <= 8'h00;
      end else begin
         done <= 1'b0;
         case (state)
            EXEC: begin
               state          <= WB;
               ControlWord[0] <= 1'b0;
               done           <= 1'b1;
               instr_count    <= instr_count + 8'd1;
            end
            default: begin
               if (take_vld) begin
                  state       <= EXEC;
                  ControlWord <= decode(take_dat);
                  ConstantIn  <= take_dat[3:0];
                  busy        <= 1'b1;
               end else begin
                  state       <= IDLE;
                  ControlWord <= 13'h0001;
                  ConstantIn  <= 4'h0;
                  busy        <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios with a queue scoreboard of write-back words.
module tb_control_sequencer;
   logic        clk = 1'b0;
   logic        nRST = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [12:0] ControlWord;
   logic [3:0]  ConstantIn;
   logic        busy;
   logic        done;
   logic [7:0]  instr_count;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [12:0] exp_q [$];
   logic [3:0]  expk_q [$];

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk         (clk),
      .nRST        (nRST),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .ControlWord (ControlWord),
      .ConstantIn  (ConstantIn),
      .busy        (busy),
      .done        (done),
      .instr_count (instr_count)
   );

   // Write-back form of the control word (nWE = 0).
   function automatic logic [12:0] ref_wb(input logic [15:0] i);
      logic [12:0] c;
      c[12:11] = i[11:10];
      c[10:9]  = i[9:8];
      c[8:7]   = i[7:6];
      c[6]     = i[5];
      c[5:2]   = i[15:12];
      c[1]     = i[4];
      c[0]     = 1'b0;
      return c;
   endfunction

   task automatic test_reset();
      nRST = 1'b0;
      instr_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ControlWord !== 13'h0001 || ConstantIn !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || instr_count !== 8'h00) begin
         n_err++;
         $display("FAIL reset_outputs: cw=%h k=%h busy=%b done=%b cnt=%h, need cw=0001 k=0 busy=0 done=0 cnt=00",
                  ControlWord, ConstantIn, busy, done, instr_count);
      end
      n_cmp++;
      if (instr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready: got %b need 0", instr_ready);
      end
      nRST = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (instr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL first_edge_ready: got %b need 0", instr_ready);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (ControlWord !== 13'h0001 || busy !== 1'b0 || instr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL idle_after_reset: cw=%h busy=%b rdy=%b, need cw=0001 busy=0 rdy=1",
                  ControlWord, busy, instr_ready);
      end
   endtask

   task automatic test_single();
      logic [12:0] e;
      logic [3:0]  ek;
      instr = 16'h5A6C;
      instr_valid = 1'b1;
      n_cmp++;
      if (instr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL single_ready: got %b need 1", instr_ready);
      end
      exp_q.push_back(13'h14D4);
      expk_q.push_back(4'hC);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr = '0;
      @(negedge clk);
      n_cmp++;
      if (ControlWord !== 13'h14D5 || ConstantIn !== 4'hC || busy !== 1'b1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL single_exec: cw=%h k=%h busy=%b done=%b, need cw=14d5 k=c busy=1 done=0",
                  ControlWord, ConstantIn, busy, done);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL single_done: got %b need 1", done);
      end else begin
         e  = exp_q.pop_front();
         ek = expk_q.pop_front();
         n_cmp++;
         if (ControlWord !== e || ConstantIn !== ek) begin
            n_err++;
            $display("FAIL single_wb: cw=%h k=%h, need cw=%h k=%h", ControlWord, ConstantIn, e, ek);
         end
      end
      n_cmp++;
      if (instr_count !== 8'd1) begin
         n_err++;
         $display("FAIL single_count: got %0d need 1", instr_count);
      end
      @(negedge clk);
      n_cmp++;
      if (ControlWord !== 13'h0001 || ConstantIn !== 4'h0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_idle: cw=%h k=%h busy=%b, need cw=0001 k=0 busy=0", ControlWord, ConstantIn, busy);
      end
      exp_q.delete();
      expk_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [15:0] src [4];
      logic [12:0] e;
      logic [3:0]  ek;
      logic [7:0]  c0;
      logic        hs;
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      int          last_done = -1;
      src[0] = 16'h1234;
      src[1] = 16'hA5F0;
      src[2] = 16'h0F0F;
      src[3] = 16'hC3E9;
      c0 = instr_count;
      instr = src[0];
      instr_valid = 1'b1;
      while (got < 4 && cyc < 100) begin
         if (done === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL b2b_unexpected_done: cw=%h with empty scoreboard", ControlWord);
            end else begin
               e  = exp_q.pop_front();
               ek = expk_q.pop_front();
               if (ControlWord !== e || ConstantIn !== ek) begin
                  n_err++;
                  $display("FAIL b2b_wb: cw=%h k=%h, need cw=%h k=%h", ControlWord, ConstantIn, e, ek);
               end
            end
            if (last_done >= 0) begin
               n_cmp++;
               if (cyc - last_done != 2) begin
                  n_err++;
                  $display("FAIL b2b_spacing: %0d cycles between writes, need 2", cyc - last_done);
               end
            end
            last_done = cyc;
            got++;
         end else if (busy === 1'b1 && ControlWord[0] === 1'b1 && exp_q.size() > 0) begin
            n_cmp++;
            if (ControlWord !== {exp_q[0][12:1], 1'b1} || ConstantIn !== expk_q[0]) begin
               n_err++;
               $display("FAIL b2b_exec: cw=%h k=%h, need cw=%h k=%h",
                        ControlWord, ConstantIn, {exp_q[0][12:1], 1'b1}, expk_q[0]);
            end
`ifndef CU_IBUF_EN
            n_cmp++;
            if (instr_ready !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_ready_in_exec: got %b need 0", instr_ready);
            end
`endif
         end
         if (got > 0 && got < 4) begin
            n_cmp++;
            if (busy !== 1'b1) begin
               n_err++;
               $display("FAIL b2b_idle_gap: busy=%b need 1 after %0d writes", busy, got);
            end
         end
         hs = instr_valid && instr_ready;
         if (hs) begin
            exp_q.push_back(ref_wb(instr));
            expk_q.push_back(instr[3:0]);
         end
         @(posedge clk);
         #1;
         if (hs) begin
            sent++;
            if (sent < 4)
               instr = src[sent];
            else
               instr_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (got != 4) begin
         n_err++;
         $display("FAIL b2b_timeout: %0d writes seen, need 4", got);
      end
      n_cmp++;
      if (instr_count !== c0 + 8'd4) begin
         n_err++;
         $display("FAIL b2b_count: got %0d need %0d", instr_count, c0 + 8'd4);
      end
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      expk_q.delete();
   endtask

   task automatic test_reset_mid_exec();
      logic [15:0] src [2];
      logic [12:0] e;
      logic        hs;
      logic        aborted = 1'b0;
      logic        saw_done = 1'b0;
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      src[0] = 16'h3C81;
      src[1] = 16'h7E42;
      instr = src[0];
      instr_valid = 1'b1;
      while (!aborted && cyc < 50) begin
         if (done === 1'b1) begin
            e = exp_q.pop_front();
            void'(expk_q.pop_front());
            n_cmp++;
            if (ControlWord !== e) begin
               n_err++;
               $display("FAIL abort_first_wb: cw=%h need %h", ControlWord, e);
            end
            got++;
         end
         if (got == 1 && busy === 1'b1 && ControlWord[0] === 1'b1) begin
            #1;
            nRST = 1'b0;
            instr_valid = 1'b0;
            #1;
            n_cmp++;
            if (ControlWord !== 13'h0001 || busy !== 1'b0 || done !== 1'b0 || instr_count !== 8'h00) begin
               n_err++;
               $display("FAIL abort_outputs: cw=%h busy=%b done=%b cnt=%h, need cw=0001 busy=0 done=0 cnt=00",
                        ControlWord, busy, done, instr_count);
            end
            aborted = 1'b1;
         end else begin
            hs = instr_valid && instr_ready;
            if (hs) begin
               exp_q.push_back(ref_wb(instr));
               expk_q.push_back(instr[3:0]);
            end
            @(posedge clk);
            #1;
            if (hs) begin
               sent++;
               if (sent < 2)
                  instr = src[sent];
               else
                  instr_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      n_cmp++;
      if (!aborted) begin
         n_err++;
         $display("FAIL abort_timeout: EXEC of second instruction not seen, got=%0d writes", got);
      end
      exp_q.delete();
      expk_q.delete();
      repeat (2) @(negedge clk);
      nRST = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1)
            saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done || instr_count !== 8'h00) begin
         n_err++;
         $display("FAIL abort_no_write: saw_done=%b cnt=%h, need saw_done=0 cnt=00", saw_done, instr_count);
      end
   endtask

   task automatic test_wrap();
      logic [12:0] e;
      logic [3:0]  ek;
      logic        hs;
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      n_cmp++;
      if (instr_count !== 8'h00) begin
         n_err++;
         $display("FAIL wrap_start: cnt=%h need 00", instr_count);
      end
      instr = 16'($urandom);
      instr_valid = 1'b1;
      while (got < 256 && cyc < 700) begin
         if (done === 1'b1) begin
            got++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL wrap_unexpected_done: cw=%h with empty scoreboard", ControlWord);
            end else begin
               e  = exp_q.pop_front();
               ek = expk_q.pop_front();
               n_cmp++;
               if (ControlWord !== e || ConstantIn !== ek) begin
                  n_err++;
                  $display("FAIL wrap_wb: write %0d cw=%h k=%h, need cw=%h k=%h", got, ControlWord, ConstantIn, e, ek);
               end
            end
            if (got == 255) begin
               n_cmp++;
               if (instr_count !== 8'hFF) begin
                  n_err++;
                  $display("FAIL wrap_255: cnt=%h need ff", instr_count);
               end
            end
            if (got == 256) begin
               n_cmp++;
               if (instr_count !== 8'h00) begin
                  n_err++;
                  $display("FAIL wrap_256: cnt=%h need 00", instr_count);
               end
            end
         end
         hs = instr_valid && instr_ready;
         if (hs) begin
            exp_q.push_back(ref_wb(instr));
            expk_q.push_back(instr[3:0]);
         end
         @(posedge clk);
         #1;
         if (hs) begin
            sent++;
            if (sent < 256)
               instr = 16'($urandom);
            else
               instr_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (got != 256) begin
         n_err++;
         $display("FAIL wrap_timeout: %0d writes seen, need 256", got);
      end
      instr_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid_exec();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
